// File: rtl/btn_debounce.sv
// Pushbutton debouncer: two-flop synchronizer plus a stability counter that qualifies level changes.
// Optional debounced-press counter enabled by defining BTN_DEBOUNCE_PRESS_CNT_EN.
module btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn,
  output logic       btn_clean,
  output logic       bouncing,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] counter_d;
  logic             clean_d;

  // Any cycle where the synchronized level agrees with btn_clean restarts qualification.
  always_comb begin
    counter_d = '0;
    clean_d   = btn_clean;
    if (sync1 != btn_clean) begin
      if (counter_q == CntLast) begin
        clean_d = sync1;
      end else begin
        counter_d = counter_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      counter_q <= '0;
      btn_clean <= 1'b0;
      bouncing  <= 1'b0;
    end else begin
      sync0     <= btn;
      sync1     <= sync0;
      counter_q <= counter_d;
      btn_clean <= clean_d;
      bouncing  <= (counter_d != '0);
    end
  end

`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
  logic [7:0] press_q;

  // Counts only 0->1 updates of btn_clean; wraps modulo 256.
  always_ff @(posedge clock) begin
    if (reset) begin
      press_q <= 8'd0;
    end else if (!btn_clean && clean_d) begin
      press_q <= press_q + 8'd1;
    end
  end

  assign press_count = press_q;
`else
  assign press_count = 8'd0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (STABLE_CYCLES=4, CNT_W=3) using a per-cycle scoreboard
// plus explicit latency measurements.
module tb_btn_debounce;

  localparam int unsigned Stable = 4;
  localparam int unsigned Lat    = Stable + 2;
`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
  localparam bit PressEn = 1'b1;
`else
  localparam bit PressEn = 1'b0;
`endif

  typedef struct {
    logic       clean;
    logic       bouncing;
    logic [7:0] press;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       btn;
  logic       btn_clean;
  logic       bouncing;
  logic [7:0] press_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model state
  logic m_s0, m_s1, m_clean;
  int   m_run, m_press;

  btn_debounce #(
    .STABLE_CYCLES(Stable),
    .CNT_W        (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn        (btn),
    .btn_clean  (btn_clean),
    .bouncing   (bouncing),
    .press_count(press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one rising edge with the given inputs.
  task automatic model_step(input logic b, input logic r, output exp_t e);
    if (r) begin
      m_s0 = 0; m_s1 = 0; m_run = 0; m_clean = 0; m_press = 0;
    end else begin
      if (m_s1 == m_clean) begin
        m_run = 0;
      end else if (m_run == Stable - 1) begin
        if (!m_clean && PressEn) m_press = (m_press + 1) % 256;
        m_clean = m_s1;
        m_run   = 0;
      end else begin
        m_run++;
      end
      m_s1 = m_s0;
      m_s0 = b;
    end
    e.clean    = m_clean;
    e.bouncing = (m_run != 0);
    e.press    = 8'(m_press);
  endtask

  task automatic cycle(input logic b, input logic r);
    exp_t e;
    btn   = b;
    reset = r;
    model_step(b, r, e);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("clean", 32'(btn_clean), 32'(e.clean));
      check("bouncing", 32'(bouncing), 32'(e.bouncing));
      check("press", 32'(press_count), 32'(e.press));
    end
  endtask

  // Holds btn for n edges; reports the first edge at which btn_clean changed (0 if none)
  // and how many edges left bouncing high.
  task automatic hold(input logic b, input int n, output int first_chg, output int busy);
    logic start;
    start     = btn_clean;
    first_chg = 0;
    busy      = 0;
    for (int i = 1; i <= n; i++) begin
      cycle(b, 1'b0);
      if (bouncing) busy++;
      if (first_chg == 0 && btn_clean != start) first_chg = i;
    end
  endtask

  initial begin
    int fc, busy;
    logic [7:0] exp_press;
    btn   = 1'b0;
    reset = 1'b1;

    // Reset with btn high, then qualification from reset release
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("rst_clean", 32'(btn_clean), 0);
    check("rst_bouncing", 32'(bouncing), 0);
    check("rst_press", 32'(press_count), 0);
    hold(1'b1, 10, fc, busy);
    check("rst_rise_lat", fc, Lat);
    check("rst_busy", busy, Stable - 1);
    hold(1'b0, 10, fc, busy);
    check("release_lat", fc, Lat);

    // Short pulse is rejected
    hold(1'b1, 3, fc, busy);
    check("short_no_chg", fc, 0);
    hold(1'b0, 10, fc, busy);
    check("short_no_chg2", fc, 0);
    check("short_pulsed", 32'(busy != 0), 1);
    check("short_idle", 32'(bouncing), 0);
    check("short_clean", 32'(btn_clean), 0);

    // Bounce train then steady high
    hold(1'b1, 1, fc, busy);  check("train0", fc, 0);
    hold(1'b0, 1, fc, busy);  check("train1", fc, 0);
    hold(1'b1, 2, fc, busy);  check("train2", fc, 0);
    hold(1'b0, 1, fc, busy);  check("train3", fc, 0);
    hold(1'b1, 12, fc, busy);
    check("train_rise_lat", fc, Lat);

    hold(1'b0, 20, fc, busy);
    check("train_fall_lat", fc, Lat);

    // Clean press and release, 20 cycles each
    hold(1'b1, 20, fc, busy);
    check("press_lat", fc, Lat);
    hold(1'b0, 20, fc, busy);
    check("rel_lat", fc, Lat);

    // Reset mid-qualification discards the partial count
    hold(1'b1, 4, fc, busy);
    check("mid_busy", 32'(bouncing), 1);
    cycle(1'b1, 1'b1);
    check("mid_rst_clean", 32'(btn_clean), 0);
    check("mid_rst_bouncing", 32'(bouncing), 0);
    hold(1'b1, 10, fc, busy);
    check("mid_requal_lat", fc, Lat);

    // 257 qualified presses
    cycle(1'b0, 1'b1);
    for (int p = 1; p <= 257; p++) begin
      hold(1'b1, Lat + 1, fc, busy);
      hold(1'b0, Lat + 1, fc, busy);
      if (p == 255 || p == 256 || p == 257) begin
        exp_press = PressEn ? 8'(p % 256) : 8'd0;
        check($sformatf("press_cnt_%0d", p), 32'(press_count), 32'(exp_press));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
